// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;

    // FSM encoding: IDLE = nothing outstanding, WAIT_RESP = one read in
    // flight, DROP = one read in flight whose data must be thrown away.
    typedef enum logic [1:0] {
        IFS_IDLE      = 2'd0,
        IFS_WAIT_RESP = 2'd1,
        IFS_DROP      = 2'd2
    } ifs_state_t;

    localparam logic [31:0] IFS_NOP = 32'h00000013;

    localparam int IFS_ENTRY_W = 64;

    // Buffer entry layout: {pc[63:32], instruction[31:0]}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous response buffer with push/pop/flush and occupancy count.
module instruction_fetch_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  logic [WIDTH-1:0]            i_wdata,
    output logic [WIDTH-1:0]            o_rdata,
    output logic [$clog2(FIFO_DEPTH):0] o_count,
    output logic                        o_empty,
    output logic                        o_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage array; contents need no reset since count guards reads.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: issues one memory read at a time from the PC stage,
// tags returned data with its PC and buffers it for decode.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | no read outstanding, may issue
// WAIT_RESP | one read outstanding, response is pushed to buffer
// DROP      | one read outstanding, response is discarded
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 2,
    parameter logic [31:0] NOP_INSTRUCTION = IFS_NOP
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        PC_VALID,
    input  logic        CLEAR_INSTRUCTION_FETCH_STAGE,
    input  logic        STALL_INSTRUCTION_FETCH_STAGE,
    output logic        STALL_PROGRAME_COUNTER_STAGE,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_REQ_VALID,
    input  logic        MEM_REQ_READY,
    input  logic        MEM_RESP_VALID,
    input  logic [31:0] MEM_RESP_DATA,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_INSTRUCTION_FETCH,
    output logic        INSTRUCTION_VALID
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifs_state_t   r_state;
    ifs_state_t   w_state_nxt;
    logic [31:0]  r_pending_pc;

    logic         w_clear;
    logic         w_resp_wait;
    logic         w_push;
    logic         w_pop;
    logic         w_fire;
    logic         w_can_issue;
    logic [CNT_W:0] w_slots;
    logic [CNT_W-1:0] w_count;
    logic         w_empty;
    logic         w_full;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_clear     = CLEAR_INSTRUCTION_FETCH_STAGE & ~RST;
    assign w_resp_wait = (r_state == IFS_WAIT_RESP) & MEM_RESP_VALID;
    assign w_pop       = ~w_empty & ~STALL_INSTRUCTION_FETCH_STAGE & ~w_clear;
    assign w_push      = w_resp_wait & ~w_clear & ~RST & ~w_full;

    // Slots claimed after this cycle: buffered entries left after the pop,
    // plus the read still owed by memory (or arriving now) in WAIT_RESP.
    assign w_slots = {1'b0, w_count}
                   - {{CNT_W{1'b0}}, w_pop}
                   + {{CNT_W{1'b0}}, (r_state == IFS_WAIT_RESP)};

    assign w_can_issue = ((r_state == IFS_IDLE) | w_resp_wait)
                       & (w_slots < (CNT_W+1)'(FIFO_DEPTH));

    assign MEM_REQ_VALID = PC_VALID & w_can_issue & ~w_clear & ~RST;
    assign w_fire        = MEM_REQ_VALID & MEM_REQ_READY;
    assign MEM_ADDR      = PC;
    assign STALL_PROGRAME_COUNTER_STAGE = RST | (~w_fire & ~w_clear);

    assign w_push_entry.pc    = r_pending_pc;
    assign w_push_entry.instr = MEM_RESP_DATA;

    instruction_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (IFS_ENTRY_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_clear),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign INSTRUCTION_VALID    = ~w_empty;
    assign INSTRUCTION          = w_empty ? NOP_INSTRUCTION : w_head.instr;
    assign PC_INSTRUCTION_FETCH = w_empty ? 32'h0 : w_head.pc;

    // State register and the PC tag of the read in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IFS_IDLE;
            r_pending_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_pending_pc <= PC;
            end
        end
    end

    // Next-state: a clear squashes any read in flight, otherwise track issue/response.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            case (r_state)
                IFS_WAIT_RESP: w_state_nxt = MEM_RESP_VALID ? IFS_IDLE : IFS_DROP;
                IFS_DROP:      w_state_nxt = MEM_RESP_VALID ? IFS_IDLE : IFS_DROP;
                default:       w_state_nxt = IFS_IDLE;
            endcase
        end else begin
            case (r_state)
                IFS_IDLE: begin
                    if (w_fire) begin
                        w_state_nxt = IFS_WAIT_RESP;
                    end
                end
                IFS_WAIT_RESP: begin
                    if (MEM_RESP_VALID) begin
                        w_state_nxt = w_fire ? IFS_WAIT_RESP : IFS_IDLE;
                    end
                end
                IFS_DROP: begin
                    if (MEM_RESP_VALID) begin
                        w_state_nxt = IFS_IDLE;
                    end
                end
                default: w_state_nxt = IFS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized bench: a PC-stage model and a latency-varying memory drive the
// fetch stage; a reference model of the delivered instruction stream feeds
// a scoreboard queue that a separate monitor checks against decode output.
module tb_instruction_fetch_stage;
    localparam int          DEPTH   = 2;
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam int          NCYC    = 3000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        CLEAR_INSTRUCTION_FETCH_STAGE;
    logic        STALL_INSTRUCTION_FETCH_STAGE;
    logic        STALL_PROGRAME_COUNTER_STAGE;
    logic [31:0] MEM_ADDR;
    logic        MEM_REQ_VALID;
    logic        MEM_REQ_READY;
    logic        MEM_RESP_VALID;
    logic [31:0] MEM_RESP_DATA;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_INSTRUCTION_FETCH;
    logic        INSTRUCTION_VALID;

    instruction_fetch_stage #(.FIFO_DEPTH(DEPTH), .NOP_INSTRUCTION(NOP)) dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .PC                            (PC),
        .PC_VALID                      (PC_VALID),
        .CLEAR_INSTRUCTION_FETCH_STAGE (CLEAR_INSTRUCTION_FETCH_STAGE),
        .STALL_INSTRUCTION_FETCH_STAGE (STALL_INSTRUCTION_FETCH_STAGE),
        .STALL_PROGRAME_COUNTER_STAGE  (STALL_PROGRAME_COUNTER_STAGE),
        .MEM_ADDR                      (MEM_ADDR),
        .MEM_REQ_VALID                 (MEM_REQ_VALID),
        .MEM_REQ_READY                 (MEM_REQ_READY),
        .MEM_RESP_VALID                (MEM_RESP_VALID),
        .MEM_RESP_DATA                 (MEM_RESP_DATA),
        .INSTRUCTION                   (INSTRUCTION),
        .PC_INSTRUCTION_FETCH          (PC_INSTRUCTION_FETCH),
        .INSTRUCTION_VALID             (INSTRUCTION_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          vis;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   prev_rst = 1'b1;
    int   n_popped = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%08h required=%08h", name, cyc, act, req);
        end
    endtask

    // Monitor: compares the decode-facing outputs with the scoreboard queue.
    always @(negedge CLK) begin
        bit exp_valid;
        exp_t e;
        if (RST && prev_rst) begin
            check("rst_valid", 32'(INSTRUCTION_VALID), 32'd0);
            check("rst_instr", INSTRUCTION, NOP);
            check("rst_pc_if", PC_INSTRUCTION_FETCH, 32'd0);
        end else if (!RST && !CLEAR_INSTRUCTION_FETCH_STAGE) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            check("instr_valid", 32'(INSTRUCTION_VALID), 32'(exp_valid));
            if (!INSTRUCTION_VALID) begin
                check("nop_when_invalid", INSTRUCTION, NOP);
            end else if (exp_valid && !STALL_INSTRUCTION_FETCH_STAGE) begin
                e = exp_q.pop_front();
                check("head_pc", PC_INSTRUCTION_FETCH, e.pc);
                check("head_instr", INSTRUCTION, e.data);
                n_popped++;
            end
        end
    end

    // Driver: PC stage and memory models, plus request-side expectations.
    initial begin
        logic [31:0] pc_r;
        bit          mem_pend;
        bit          squashed;
        logic [31:0] mem_addr;
        int          mem_cnt;
        bit          resp_now;
        bit          exp_req;
        bit          fire_m;
        bit          pop_m;
        int          slots;
        bit          directed;

        RST = 1'b1; PC = '0; PC_VALID = 1'b1;
        CLEAR_INSTRUCTION_FETCH_STAGE = 1'b0;
        STALL_INSTRUCTION_FETCH_STAGE = 1'b0;
        MEM_REQ_READY = 1'b1; MEM_RESP_VALID = 1'b0; MEM_RESP_DATA = '0;
        pc_r = '0; mem_pend = 0; squashed = 0; mem_addr = '0; mem_cnt = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLK);
            #2;
            prev_rst = RST;
            cyc = c;
            directed = (c < 200);
            RST = (c < 2) || (c >= 1500 && c < 1502);
            if (RST) begin
                mem_pend = 0;
                squashed = 0;
                exp_q.delete();
                pc_r = '0;
            end
            resp_now = mem_pend && (mem_cnt == 0);

            PC       = pc_r;
            PC_VALID = directed ? 1'b1 : ($urandom_range(0, 9) != 0);
            CLEAR_INSTRUCTION_FETCH_STAGE = RST ? 1'b0 :
                (directed ? 1'b0 : ($urandom_range(0, 15) == 0));
            STALL_INSTRUCTION_FETCH_STAGE = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
            MEM_REQ_READY  = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            MEM_RESP_VALID = resp_now;
            MEM_RESP_DATA  = resp_now ? mem_f(mem_addr) : $urandom();
            #1;

            pop_m = (exp_q.size() > 0) && !STALL_INSTRUCTION_FETCH_STAGE;
            slots = exp_q.size() - int'(pop_m) + int'(mem_pend && !squashed);
            exp_req = !RST && PC_VALID && !CLEAR_INSTRUCTION_FETCH_STAGE
                    && (!mem_pend || (resp_now && !squashed))
                    && (slots < DEPTH);
            fire_m = exp_req && MEM_REQ_READY;

            check("mem_req_valid", 32'(MEM_REQ_VALID), 32'(exp_req));
            check("mem_addr", MEM_ADDR, pc_r);
            check("stall_pc", 32'(STALL_PROGRAME_COUNTER_STAGE),
                  32'(RST || (!fire_m && !CLEAR_INSTRUCTION_FETCH_STAGE)));

            if (resp_now) begin
                if (!squashed && !CLEAR_INSTRUCTION_FETCH_STAGE && !RST) begin
                    exp_q.push_back('{pc: mem_addr, data: mem_f(mem_addr), vis: c + 1});
                end
                mem_pend = 0;
            end
            if (CLEAR_INSTRUCTION_FETCH_STAGE) begin
                exp_q.delete();
                if (mem_pend) squashed = 1;
            end
            if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (fire_m) begin
                mem_pend = 1;
                squashed = 0;
                mem_addr = pc_r;
                mem_cnt  = directed ? 0 :
                    (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
            end

            if (RST)
                pc_r = '0;
            else if (CLEAR_INSTRUCTION_FETCH_STAGE)
                pc_r = {$urandom_range(0, 32'h3FFF), 2'b00};
            else if (fire_m)
                pc_r = pc_r + 32'd4;
        end

        @(posedge CLK);
        #2;
        n_cmp++;
        if (n_popped < 100) begin
            n_fail++;
            $display("FAIL delivered_count actual=%0d required>=100", n_popped);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Consumer end of the PC interface. Takes PC/PC_VALID from the program counter stage and issues instruction-memory reads.
- Buffers returned instructions, tagged with their PC, for the decoding stage.
- Drives STALL_PROGRAME_COUNTER_STAGE back to the PC stage.
- Honours CLEAR_INSTRUCTION_FETCH_STAGE by discarding wrong-path state, including a read already in flight.

Parameters:
- FIFO_DEPTH, 2, entries in the response buffer (power of two, ≥2).
- NOP_INSTRUCTION, 32'h00000013, value driven on INSTRUCTION when the output is invalid.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- PC  input  32  fetch address from the PC stage.
- PC_VALID  input  1  PC is a valid fetch address.
- CLEAR_INSTRUCTION_FETCH_STAGE  input  1  redirect/flush from the PC stage.
- STALL_INSTRUCTION_FETCH_STAGE  input  1  decode cannot accept an instruction this cycle.
- STALL_PROGRAME_COUNTER_STAGE  output  1  PC stage must hold pc_reg.
- MEM_ADDR  output  32  read address, equal to PC.
- MEM_REQ_VALID  output  1  read request valid.
- MEM_REQ_READY  input  1  memory accepts the request.
- MEM_RESP_VALID  input  1  read data valid.
- MEM_RESP_DATA  input  32  read data.
- INSTRUCTION  output  32  instruction at the buffer head.
- PC_INSTRUCTION_FETCH  output  32  PC of INSTRUCTION.
- INSTRUCTION_VALID  output  1  buffer head valid.

Behaviour:
- **Single clock, CLK.** RST is synchronous and active-high.
- **Reset values:**
  - FSM = IDLE, buffer empty, outstanding = 0.
  - INSTRUCTION_VALID = 0, INSTRUCTION = NOP_INSTRUCTION, PC_INSTRUCTION_FETCH = 0.
  - MEM_REQ_VALID = 0, STALL_PROGRAME_COUNTER_STAGE = 1 while RST is high.
- **FSM states:** IDLE (nothing outstanding), WAIT_RESP (one read outstanding), DROP (one outstanding read to be discarded). At most one read is outstanding.
- **can_issue** = (IDLE, or WAIT_RESP with MEM_RESP_VALID this cycle) and (occupancy_after_pop + outstanding_after_resp) < FIFO_DEPTH.
- **Request handshake:**
  - MEM_REQ_VALID = PC_VALID & can_issue & !CLEAR & !RST. MEM_REQ_VALID never depends on MEM_REQ_READY.
  - fire = MEM_REQ_VALID & MEM_REQ_READY. MEM_ADDR = PC, combinational.
- **Stall to PC stage:** STALL_PROGRAME_COUNTER_STAGE = RST | (!fire & !CLEAR). During a clear it is low, so the PC stage loads the redirect target.
- **On fire:** capture PC into pending_pc, go to WAIT_RESP. Back-to-back is allowed: response and new fire in the same cycle stays in WAIT_RESP, giving 1 instruction/cycle with a 1-cycle-latency memory.
- **Response in WAIT_RESP:** push {pending_pc, MEM_RESP_DATA}; the entry is visible on the outputs the next cycle.
- **Response in IDLE:** ignored.
- **Pop:** when INSTRUCTION_VALID & !STALL_INSTRUCTION_FETCH_STAGE. Push and pop in the same cycle keep occupancy unchanged; push to a full buffer cannot occur by construction.
- **Output drive:** INSTRUCTION_VALID = buffer non-empty. INSTRUCTION / PC_INSTRUCTION_FETCH come from the head; INSTRUCTION = NOP_INSTRUCTION when invalid.
- **CLEAR (highest priority after RST):**
  - Buffer flushed next cycle; no push or issue this cycle.
  - WAIT_RESP without response → DROP.
  - WAIT_RESP with response this cycle → data discarded, → IDLE.
  - IDLE → IDLE.
  - DROP → DROP, or → IDLE if a response arrives.
- **DROP:** no issue. The next MEM_RESP_VALID is discarded and the FSM → IDLE; issue resumes the following cycle.
- **RST mid-operation:** all state cleared, and an in-flight read's response is ignored because the FSM is in IDLE. The memory must not respond to a request accepted before reset.
- **Width:** occupancy counter is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, WAIT_RESP=2'd1, DROP=2'd2);
  - the default NOP constant 32'h00000013;
  - the 64-bit fetch-entry layout {pc[63:32], instruction[31:0]}.
- Sub-module instruction_fetch_fifo: synchronous FIFO with push/pop/flush, parameterised FIFO_DEPTH and width 64, exposing count, empty and full.

Test Plan:
- **Reset:** RST high 2 cycles with PC_VALID=1 → MEM_REQ_VALID=0, STALL_PROGRAME_COUNTER_STAGE=1, INSTRUCTION_VALID=0, INSTRUCTION=0x00000013.
- **Streaming:** 1-cycle memory, always ready, PC=0,4,8,… → one fire per cycle, stall low; decode sees (PC 0x0, data) two cycles after the first fire and one entry per cycle after that.
- **Decode stall:** STALL_INSTRUCTION_FETCH_STAGE=1 for 5 cycles → buffer fills to 2, then MEM_REQ_VALID=0 and stall=1. Release → PC 0x8, 0xC drain in order, no loss or duplication.
- **Memory backpressure:** MEM_REQ_READY=0 for 3 cycles → MEM_ADDR held at 0x10, stall=1; READY=1 → single fire at 0x10.
- **Redirect in flight:** fire 0x20, CLEAR next cycle, response 3 cycles later → response discarded, buffer empty. The next fire is at the redirect target 0x100 only after DROP exits, and 0x20's data never reaches decode.
- **Clear with same-cycle response:** CLEAR and MEM_RESP_VALID in the same cycle → FSM IDLE, nothing pushed, INSTRUCTION_VALID=0 the next cycle.
